izh_neuron_update: RTL
======================

# izh_neuron_update

Per-timestep Izhikevich neuron update engine and spike-tag source; the producer end of the fired-tag FIFO / current-swap protocol whose consumer is the synaptic accumulator. For each `step` it reads every neuron's input current by tag and updates its membrane state (v, u). It enqueues the tag of every neuron that fires, waits for the accumulator to drain all spikes, issues `swap`, then pulses `done`.

## Interface
- `numwidth`, 16: current/state width is numwidth+1 (17 bits).
- `tagbits`, 1: neuron tag width.
- `numneurons`, 2: neurons swept per step.
- `fracbits`, 8: fractional bits of every fixed-point value.
- `fifo_depth`, numneurons: spike-tag FIFO entries.
- `A`, 5; `B`, 51; `C`, -16640; `D`, 2048; `VPEAK`, 7680: Izhikevich a, b, c, d and spike threshold in Q.fracbits.
- Ports:
  - `clk` in 1: clock.
  - `asyn_reset` in 1: asynchronous, active-high reset.
  - `step` in 1: start one timestep; sampled only in IDLE.
  - `done` out 1: one-cycle pulse when the timestep is complete.
  - `fifo_empty` out 1: FIFO holds no tags.
  - `fired_tag` out tagbits: FIFO head; valid while `!fifo_empty`.
  - `req_deq` in 1: pop head at this edge; ignored when empty.
  - `i_tag` out tagbits: neuron index for the current read.
  - `i_out` in numwidth+1: current for `i_tag`; unsigned Q.fracbits, valid one cycle after `i_tag`.
  - `swap` out 1: request that the accumulator swap current banks.
  - `busy` in 1: accumulator non-idle.
  - `probe_tag` in tagbits / `v_probe` out numwidth+1: registered v of the probed neuron.
  - `state_out` out 3: FSM state.

## Operation
- Per-neuron state: v, u, each signed numwidth+1.
  - Reset values: v=C, u=(B*C)>>>fracbits (-3315 with defaults).
- FSM states: IDLE, FETCH, UPDATE, PUSH_WAIT, DRAIN, SWAP, SWAP_WAIT.
  - IDLE: on `step`, n<=0 and go to FETCH.
  - FETCH: drive `i_tag`=n, go to UPDATE.
  - UPDATE: `i_out` is valid. Compute v', u' and write back.
    - If fired and FIFO not full: push n.
    - If fired and FIFO full: go to PUSH_WAIT (state already written).
    - Otherwise: n+1 → FETCH, or after the last neuron → DRAIN.
  - PUSH_WAIT: push n on the first non-full cycle, then continue as UPDATE does.
  - DRAIN: wait for `fifo_empty && !busy`, then go to SWAP.
  - SWAP: `swap`=1 for exactly this cycle, then go to SWAP_WAIT.
  - SWAP_WAIT: hold while `busy`; on `!busy`, go to IDLE and assert `done` in the next cycle.
- Arithmetic:
  - Signed, at least 40-bit intermediates; I = zero-extended `i_out`.
  - v' = v + ((41*v*v)>>>(fracbits+10)) + 5v + (140<<fracbits) − u + I.
  - u' = u + ((A*(((B*v)>>>fracbits) − u))>>>fracbits). Both use the old v and u.
  - Saturate v' and u' to the signed numwidth+1 range.
  - Fired iff saturated v' >= VPEAK. Then v<=C and u<=sat(u'+D).
- FIFO:
  - Show-ahead; `fired_tag` stays stable until popped.
  - Simultaneous push and pop: both take effect and the count is unchanged.
  - Push of the only entry while empty: `fifo_empty` falls the next cycle.
- `step` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0 (`fired_tag`, `i_tag`, `v_probe`=0), state IDLE, FIFO empty so `fifo_empty`=1.
- `asyn_reset` mid-step aborts the step immediately and restores all reset values, including v, u and the FIFO.
- Unstalled sweep: 2 cycles per neuron.
- After the sweep: DRAIN takes at least 1 cycle, SWAP 1, SWAP_WAIT 2 (one `busy`-high cycle, then low), then `done`.
- Minimum step-to-done with no spikes: 2·numneurons+5 cycles.
- `v_probe` lags `probe_tag` by 1 cycle and reflects write-backs one cycle after UPDATE.

## Structure
- Package `izh_pkg` holds:
  - state encodings;
  - default A/B/C/D/VPEAK and the 41/140 constants;
  - the saturate-to-width function.
- Sub-module `spike_tag_fifo` (push/pop/full/empty/head, parameterized depth and width). The FSM and the datapath stay in the top.

## Test plan
- Reset with a stub accumulator and `i_out`=0, then pulse `step` → no push; v[0] probe = -17379, u[0] = -3315; `done` on cycle 2N+5.
- `i_out`=0x10000 for tag 1 only → tag 1 pushed; v[1] = -16640, u[1] = -1267; `fired_tag`=1 until `req_deq`.
- Both neurons fire with a stub that never deqs and `fifo_depth`=1 → PUSH_WAIT holds; one `req_deq` releases it; `swap` is not asserted until empty and `!busy`.
- Hold `busy`=1 for 10 cycles after the sweep → `swap` is delayed accordingly and asserted for exactly 1 cycle.
- `asyn_reset` during UPDATE of tag 1 → all outputs 0, `fifo_empty`=1, v=-16640; the next `step` behaves as the first.
- Simultaneous `req_deq` and push on a 1-entry FIFO → count stays at 1 and head = new tag.

Source files
------------

// File: rtl/izh_pkg.sv
// Shared state encoding, default neuron constants and the saturation helper
// used by the Izhikevich update engine.
package izh_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_UPDATE    = 3'd2,
        ST_PUSH_WAIT = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_SWAP      = 3'd5,
        ST_SWAP_WAIT = 3'd6
    } izh_state_t;

    // Default Izhikevich a, b, c, d and spike threshold, all in Q.8
    localparam int IZH_A     = 5;
    localparam int IZH_B     = 51;
    localparam int IZH_C     = -16640;
    localparam int IZH_D     = 2048;
    localparam int IZH_VPEAK = 7680;

    // 0.04*v^2 is realised as 41*v^2 / 2^(fracbits+10); 5v and 140 are plain terms
    localparam int IZH_SQ_COEF  = 41;
    localparam int IZH_SQ_SHIFT = 10;
    localparam int IZH_LIN_COEF = 5;
    localparam int IZH_BIAS     = 140;

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/spike_tag_fifo.sv
// Show-ahead FIFO for fired neuron tags; a pop frees room for a push in the
// same cycle, so a full FIFO still accepts a tag while it is being drained.
module spike_tag_fifo #(
    parameter int depth = 2,
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             asyn_reset,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] head
);

    localparam int PW    = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW    = $clog2(depth + 1);
    localparam int SLOTS = 1 << PW;
    localparam logic [PW-1:0] LAST_SLOT = PW'(depth - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(depth);

    logic [width-1:0] mem [SLOTS];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < SLOTS; k++)
                mem[k] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/izh_neuron_update.sv
// Per-timestep Izhikevich neuron sweep: reads each neuron's current, updates
// (v, u), queues fired tags, then hands the current banks over with swap/done.
module izh_neuron_update
    import izh_pkg::*;
#(
    parameter int numwidth   = 16,
    parameter int tagbits    = 1,
    parameter int numneurons = 2,
    parameter int fracbits   = 8,
    parameter int fifo_depth = numneurons,
    parameter int A          = IZH_A,
    parameter int B          = IZH_B,
    parameter int C          = IZH_C,
    parameter int D          = IZH_D,
    parameter int VPEAK      = IZH_VPEAK
) (
    input  logic                clk,
    input  logic                asyn_reset,
    input  logic                step,
    output logic                done,
    output logic                fifo_empty,
    output logic [tagbits-1:0]  fired_tag,
    input  logic                req_deq,
    output logic [tagbits-1:0]  i_tag,
    input  logic [numwidth:0]   i_out,
    output logic                swap,
    input  logic                busy,
    input  logic [tagbits-1:0]  probe_tag,
    output logic [numwidth:0]   v_probe,
    output logic [2:0]          state_out
);

    localparam int W  = numwidth + 1;
    localparam int XW = 48;

    typedef logic signed [W-1:0]  sval_t;
    typedef logic signed [XW-1:0] xval_t;

    localparam xval_t A_X     = xval_t'(A);
    localparam xval_t B_X     = xval_t'(B);
    localparam xval_t C_X     = xval_t'(C);
    localparam xval_t D_X     = xval_t'(D);
    localparam xval_t SQ_X    = xval_t'(IZH_SQ_COEF);
    localparam xval_t LIN_X   = xval_t'(IZH_LIN_COEF);
    localparam xval_t BIAS_X  = xval_t'(IZH_BIAS) <<< fracbits;
    localparam xval_t U_RST_X = (B_X * C_X) >>> fracbits;

    localparam sval_t C_V     = sval_t'(C_X);
    localparam sval_t U_RST   = sval_t'(U_RST_X);
    localparam sval_t VPEAK_V = sval_t'(VPEAK);
    localparam logic [tagbits-1:0] LAST_N = tagbits'(numneurons - 1);

    izh_state_t         state;
    izh_state_t         state_next;
    logic [tagbits-1:0] n;
    logic [tagbits-1:0] n_next;
    logic               done_set;
    logic               push;
    logic               wr_en;
    logic               fifo_full;
    logic               can_push;
    logic               at_last;

    sval_t v_mem [numneurons];
    sval_t u_mem [numneurons];

    sval_t v_cur;
    sval_t u_cur;
    xval_t v_x;
    xval_t u_x;
    xval_t i_x;
    xval_t sq_term;
    xval_t v_raw;
    xval_t bv_term;
    xval_t u_raw;
    sval_t v_sat;
    sval_t u_sat;
    sval_t u_fire;
    logic  fired;

    spike_tag_fifo #(
        .depth (fifo_depth),
        .width (tagbits)
    ) u_fifo (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .push       (push),
        .push_data  (n),
        .pop        (req_deq),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fired_tag)
    );

    // A pop in the same cycle makes room even when the FIFO is full
    assign can_push  = !fifo_full || (req_deq && !fifo_empty);
    assign at_last   = (n == LAST_N);
    assign i_tag     = n;
    assign state_out = state;

    always_comb begin
        v_cur   = v_mem[n];
        u_cur   = u_mem[n];
        v_x     = xval_t'(v_cur);
        u_x     = xval_t'(u_cur);
        i_x     = xval_t'({1'b0, i_out});
        sq_term = (SQ_X * v_x * v_x) >>> (fracbits + IZH_SQ_SHIFT);
        v_raw   = v_x + sq_term + LIN_X * v_x + BIAS_X - u_x + i_x;
        bv_term = (B_X * v_x) >>> fracbits;
        u_raw   = u_x + ((A_X * (bv_term - u_x)) >>> fracbits);
        v_sat   = sval_t'(sat_signed(64'(v_raw), W));
        u_sat   = sval_t'(sat_signed(64'(u_raw), W));
        u_fire  = sval_t'(sat_signed(64'(xval_t'(u_sat) + D_X), W));
        fired   = (v_sat >= VPEAK_V);
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state <= ST_IDLE;
            n     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            n     <= n_next;
            done  <= done_set;
        end
    end

    always_comb begin
        state_next = state;
        n_next     = n;
        push       = 1'b0;
        wr_en      = 1'b0;
        swap       = 1'b0;
        done_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (step) begin
                    n_next     = '0;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_UPDATE;
            ST_UPDATE: begin
                // State is written back even if the tag must wait for room
                wr_en = 1'b1;
                if (fired && !can_push) begin
                    state_next = ST_PUSH_WAIT;
                end else begin
                    push = fired;
                    if (at_last) begin
                        state_next = ST_DRAIN;
                    end else begin
                        n_next     = n + 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_PUSH_WAIT: begin
                if (can_push) begin
                    push = 1'b1;
                    if (at_last) begin
                        state_next = ST_DRAIN;
                    end else begin
                        n_next     = n + 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !busy)
                    state_next = ST_SWAP;
            end
            ST_SWAP: begin
                swap       = 1'b1;
                state_next = ST_SWAP_WAIT;
            end
            ST_SWAP_WAIT: begin
                if (!busy) begin
                    done_set   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            v_probe <= '0;
            for (int k = 0; k < numneurons; k++) begin
                v_mem[k] <= C_V;
                u_mem[k] <= U_RST;
            end
        end else begin
            v_probe <= v_mem[probe_tag];
            if (wr_en) begin
                v_mem[n] <= fired ? C_V : v_sat;
                u_mem[n] <= fired ? u_fire : u_sat;
            end
        end
    end

endmodule
